// File: rtl/hall_decoder.sv
// Hall sensor front end: synchroniser, debounce, sector decode, direction, step
// period, stall and fault. Define HALL_SPEED_FILTER_EN to average the last 4 periods.
module hall_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PERIOD_W        = 24,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          HS,
  input  logic                fault_clr,
  output logic [2:0]          sector,
  output logic                step,
  output logic                dir_cw,
  output logic                dir_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stalled,
  output logic                hall_fault
);
  typedef enum logic {ST_ACQUIRE, ST_RUN} state_t;

  localparam logic [7:0]          DB_N      = 8'(DEBOUNCE_CYCLES);
  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT_CYCLES);

  function automatic logic [2:0] f_decode(input logic [2:0] code);
    case (code)
      3'b001:  f_decode = 3'd0;
      3'b011:  f_decode = 3'd1;
      3'b010:  f_decode = 3'd2;
      3'b110:  f_decode = 3'd3;
      3'b100:  f_decode = 3'd4;
      3'b101:  f_decode = 3'd5;
      default: f_decode = 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] f_next(input logic [2:0] s);
    f_next = (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] f_prev(input logic [2:0] s);
    f_prev = (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  logic [2:0]          r_sync1, r_sync2, r_cand, r_code;
  logic [7:0]          r_db_cnt;
  state_t              r_state;
  logic [2:0]          r_sector;
  logic                r_step, r_dir_cw, r_dir_valid, r_period_valid;
  logic                r_stalled, r_hall_fault, r_have_ref;
  logic [PERIOD_W-1:0] r_period, r_cnt;

  logic                w_accept, w_is_cw, w_is_ccw, w_step_ev, w_meas, w_stall;
  logic [2:0]          w_new_sec;

  // Input path: two-flop synchroniser, then run-length count of identical samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 3'b000;
      r_sync2  <= 3'b000;
      r_cand   <= 3'b000;
      r_db_cnt <= 8'd0;
    end else begin
      r_sync1 <= HS;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand   <= r_sync2;
        r_db_cnt <= 8'd1;
      end else if (r_db_cnt != DB_N) begin
        r_db_cnt <= r_db_cnt + 8'd1;
      end
    end
  end

  // A stable code is acted on once, when it first differs from the last accepted one
  assign w_accept  = (r_db_cnt == DB_N) && (r_cand != r_code);
  assign w_new_sec = f_decode(r_cand);
  assign w_is_cw   = (r_state == ST_RUN) && (w_new_sec == f_next(r_sector));
  assign w_is_ccw  = (r_state == ST_RUN) && (w_new_sec == f_prev(r_sector));
  assign w_step_ev = w_accept && (w_is_cw || w_is_ccw);
  assign w_meas    = w_step_ev && r_have_ref && (w_is_cw == r_dir_cw) && (r_cnt != CNT_MAX);
  assign w_stall   = !w_accept && (r_state == ST_RUN) && (r_cnt >= TIMEOUT_V);

`ifdef HALL_SPEED_FILTER_EN
  logic [PERIOD_W-1:0] r_hist0, r_hist1, r_hist2;
  logic [1:0]          r_nmeas;
  logic [PERIOD_W+1:0] w_sum;
  logic [PERIOD_W-1:0] w_avg;

  assign w_sum = {2'b00, r_hist0} + {2'b00, r_hist1} + {2'b00, r_hist2} + {2'b00, r_cnt};
  assign w_avg = w_sum[PERIOD_W+1:2];

  // Any accepted code other than a same-direction measurement restarts the history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nmeas <= 2'd0;
    end else if (w_meas) begin
      r_hist0 <= r_cnt;
      r_hist1 <= r_hist0;
      r_hist2 <= r_hist1;
      if (r_nmeas != 2'd3) r_nmeas <= r_nmeas + 2'd1;
    end else if (w_accept || w_stall) begin
      r_nmeas <= 2'd0;
    end
  end
`endif

  // Sector / direction / period / stall / fault state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_ACQUIRE;
      r_code         <= 3'b000;
      r_sector       <= 3'd7;
      r_step         <= 1'b0;
      r_dir_cw       <= 1'b0;
      r_dir_valid    <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_stalled      <= 1'b0;
      r_hall_fault   <= 1'b0;
      r_have_ref     <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_step <= 1'b0;
      r_cnt  <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
      if (fault_clr) r_hall_fault <= 1'b0;
      if (w_accept) begin
        r_code   <= r_cand;
        r_sector <= w_new_sec;
        if (w_new_sec == 3'd7) begin
          r_hall_fault   <= 1'b1;
          r_dir_valid    <= 1'b0;
          r_period_valid <= 1'b0;
          r_have_ref     <= 1'b0;
          r_stalled      <= 1'b0;
          r_state        <= ST_ACQUIRE;
        end else if (w_step_ev) begin
          r_step      <= 1'b1;
          r_dir_cw    <= w_is_cw;
          r_dir_valid <= 1'b1;
          r_stalled   <= 1'b0;
          r_have_ref  <= 1'b1;
          r_cnt       <= CNT_ONE;
          if (w_meas) begin
`ifdef HALL_SPEED_FILTER_EN
            if (r_nmeas == 2'd3) begin
              r_period       <= w_avg;
              r_period_valid <= 1'b1;
            end
`else
            r_period       <= r_cnt;
            r_period_valid <= 1'b1;
`endif
          end else begin
            r_period_valid <= 1'b0;
          end
        end else begin
          // First code after acquire, or a skipped sector treated as a fresh acquire;
          // the stall timer restarts here as well as on steps
          if (r_state == ST_RUN) r_hall_fault <= 1'b1;
          r_state        <= ST_RUN;
          r_dir_valid    <= 1'b0;
          r_period_valid <= 1'b0;
          r_have_ref     <= 1'b0;
          r_stalled      <= 1'b0;
          r_cnt          <= CNT_ONE;
        end
      end else if (w_stall) begin
        r_stalled      <= 1'b1;
        r_dir_valid    <= 1'b0;
        r_period_valid <= 1'b0;
        r_have_ref     <= 1'b0;
      end
    end
  end

  assign sector       = r_sector;
  assign step         = r_step;
  assign dir_cw       = r_dir_cw;
  assign dir_valid    = r_dir_valid;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign stalled      = r_stalled;
  assign hall_fault   = r_hall_fault;
endmodule

// File: tb/tb_hall_decoder.sv
// Bench for hall_decoder: directed scenarios plus randomized Hall sequences, checked
// every cycle against a behavioural model built from sample windows and cycle stamps.
module tb_hall_decoder;
  localparam int D  = 4;
  localparam int PW = 24;
  localparam int TO = 500;

  logic          clk = 1'b0;
  logic          rst_n, fault_clr;
  logic [2:0]    HS;
  logic [2:0]    sector;
  logic          step, dir_cw, dir_valid, period_valid, stalled, hall_fault;
  logic [PW-1:0] period;

  hall_decoder #(.DEBOUNCE_CYCLES(D), .PERIOD_W(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .HS(HS), .fault_clr(fault_clr),
    .sector(sector), .step(step), .dir_cw(dir_cw), .dir_valid(dir_valid),
    .period(period), .period_valid(period_valid), .stalled(stalled),
    .hall_fault(hall_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_step_cyc = -1;
  int stall_cyc     = -1;
  bit prev_stalled  = 1'b0;

  int       dec_tab[8] = '{7, 0, 2, 1, 4, 5, 3, 7};
  logic [2:0] enc_tab[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  // Reference model state
  int q[$];
  int m_sector = 7, m_period = 0, m_code = 0, m_last = 0, mcyc = 0;
  bit m_step = 0, m_cw = 0, m_dv = 0, m_pv = 0, m_stall = 0, m_fault = 0;
  bit m_run = 0, m_ref = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int c; bit ev; int s; int d; bit cw;
    mcyc++;
    if (!rst_n) begin
      m_sector = 7; m_step = 0; m_cw = 0; m_dv = 0; m_pv = 0; m_period = 0;
      m_stall = 0; m_fault = 0; m_run = 0; m_ref = 0; m_code = 0; m_last = mcyc;
      q.delete();
      for (int i = 0; i < D + 2; i++) q.push_back(0);
      return;
    end
    m_step = 0;
    // q holds HS at the last D+2 edges; the oldest D must agree to accept a code
    c  = q[0];
    ev = (c != m_code);
    for (int i = 1; i < D; i++) if (q[i] != c) ev = 0;
    q.push_back(int'(HS));
    void'(q.pop_front());
    if (fault_clr) m_fault = 0;
    if (ev) begin
      m_code = c;
      s = dec_tab[c];
      if (s == 7) begin
        m_fault = 1; m_sector = 7; m_dv = 0; m_pv = 0; m_ref = 0; m_stall = 0; m_run = 0;
      end else begin
        d = (s - m_sector + 6) % 6;
        if (m_run && (d == 1 || d == 5)) begin
          cw = (d == 1);
          m_step = 1;
          if (m_ref && cw == m_cw) begin
            m_period = mcyc - m_last;
            m_pv = 1;
          end else begin
            m_pv = 0;
          end
          m_cw = cw; m_dv = 1; m_stall = 0; m_ref = 1;
        end else begin
          if (m_run) m_fault = 1;
          m_dv = 0; m_pv = 0; m_ref = 0; m_stall = 0; m_run = 1;
        end
        m_sector = s;
        m_last = mcyc;
      end
    end else if (m_run && (mcyc - m_last) >= TO) begin
      m_stall = 1; m_dv = 0; m_pv = 0; m_ref = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("sector", int'(sector), m_sector);
    check("step", int'(step), int'(m_step));
    check("dir_cw", int'(dir_cw), int'(m_cw));
    check("dir_valid", int'(dir_valid), int'(m_dv));
    check("period", int'(period), m_period);
    check("period_valid", int'(period_valid), int'(m_pv));
    check("stalled", int'(stalled), int'(m_stall));
    check("hall_fault", int'(hall_fault), int'(m_fault));
    if (step) last_step_cyc = cyc;
    if (stalled && !prev_stalled) stall_cyc = cyc;
    prev_stalled = stalled;
  endtask

  task automatic hold(input logic [2:0] v, input int n, input bit rclr);
    HS = v;
    for (int i = 0; i < n; i++) begin
      fault_clr = rclr && ($urandom_range(0, 24) == 0);
      tick();
    end
    fault_clr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    bit dir;
    int r;
    rst_n = 1'b0; HS = 3'b000; fault_clr = 1'b0;
    for (int i = 0; i < D + 2; i++) q.push_back(0);
    do_reset(5);
    check("rst_sector", int'(sector), 7);
    check("rst_fault", int'(hall_fault), 0);
    hold(3'b000, 3, 0);

    // Acquire: sector visible 6 edges after first sample, no step
    hold(3'b001, 6, 0);
    check("acq_early", int'(sector), 7);
    hold(3'b001, 1, 0);
    check("acq_sector", int'(sector), 0);
    check("acq_step", int'(step), 0);
    check("acq_dv", int'(dir_valid), 0);
    hold(3'b001, 93, 0);

    // Clockwise steps 100 cycles apart
    hold(3'b011, 100, 0);
    hold(3'b010, 10, 0);
    check("cw_period", int'(period), 100);
    check("cw_pv", int'(period_valid), 1);
    check("cw_dir", int'(dir_cw), 1);
    check("cw_sector", int'(sector), 2);

    // Short glitch at sector 2 is ignored
    hold(3'b010, 30, 0);
    hold(3'b110, 2, 0);
    hold(3'b010, 60, 0);
    check("glitch_sector", int'(sector), 2);
    check("glitch_fault", int'(hall_fault), 0);
    hold(3'b110, 100, 0);
    check("cw3_sector", int'(sector), 3);
    check("cw3_period", int'(period), 102);

    // Reversal, then a counter-clockwise measurement of 80
    hold(3'b010, 80, 0);
    check("rev_dir", int'(dir_cw), 0);
    check("rev_pv", int'(period_valid), 0);
    check("rev_sector", int'(sector), 2);
    hold(3'b011, 10, 0);
    check("ccw_period", int'(period), 80);
    check("ccw_pv", int'(period_valid), 1);
    check("ccw_sector", int'(sector), 1);

    // Invalid code, then clear and re-acquire
    hold(3'b111, 20, 0);
    check("inv_fault", int'(hall_fault), 1);
    check("inv_sector", int'(sector), 7);
    HS = 3'b001; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    hold(3'b001, 20, 0);
    check("clr_fault", int'(hall_fault), 0);
    check("clr_sector", int'(sector), 0);

    // New fault on the same edge as fault_clr: fault wins
    HS = 3'b111;
    for (int i = 0; i < 6; i++) tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("fault_wins", int'(hall_fault), 1);
    HS = 3'b001; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    hold(3'b001, 20, 0);

    // Stall 500 cycles after the last step, cleared by the next step
    stall_cyc = -1;
    hold(3'b011, 600, 0);
    check("stall_delay", stall_cyc - last_step_cyc, TO);
    check("stall_flag", int'(stalled), 1);
    check("stall_dv", int'(dir_valid), 0);
    check("stall_pv", int'(period_valid), 0);
    hold(3'b010, 20, 0);
    check("unstall_flag", int'(stalled), 0);
    check("unstall_dv", int'(dir_valid), 1);
    check("unstall_pv", int'(period_valid), 0);

    // Randomized rotation with reversals, skips, invalid codes, glitches, stalls, resets
    p = 2;
    dir = 1'b1;
    for (int s = 0; s < 250; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        if ($urandom_range(0, 9) == 0) dir = ~dir;
        p = (p + (dir ? 1 : 5)) % 6;
        hold(enc_tab[p], $urandom_range(1, 150), 1);
      end else if (r < 78) begin
        p = (p + 2 + $urandom_range(0, 2)) % 6;
        hold(enc_tab[p], $urandom_range(5, 120), 1);
      end else if (r < 83) begin
        hold(($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000, $urandom_range(1, 60), 1);
      end else if (r < 93) begin
        hold(3'($urandom_range(0, 7)), $urandom_range(1, D - 1), 1);
        hold(enc_tab[p], $urandom_range(1, 100), 1);
      end else if (r < 96) begin
        hold(enc_tab[p], $urandom_range(480, 700), 1);
      end else begin
        do_reset($urandom_range(1, 4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
